// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM page core: command opcodes, FSM states
// and the response acknowledge encoding.
package eeprom_pkg;

  typedef enum logic [1:0] {
    OP_SET_ADDR = 2'd0,
    OP_WRITE    = 2'd1,
    OP_READ     = 2'd2,
    OP_STOP     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PROGRAM = 2'd2
  } state_e;

  localparam logic RSP_NACK = 1'b1;
  localparam logic RSP_ACK  = 1'b0;

endpackage

// File: rtl/eeprom_page_buf.sv
// Page write buffer: byte storage, per-column dirty mask and a column counter
// that wraps inside the page.
module eeprom_page_buf #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PAGE_SIZE = 8,
  localparam int unsigned COL_W    = $clog2(PAGE_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear_i,
  input  logic                              load_i,
  input  logic [DATA_W-1:0]                 wdata_i,
  input  logic [COL_W-1:0]                  start_col_i,
  output logic [COL_W-1:0]                  cur_col_o,
  output logic [PAGE_SIZE-1:0][DATA_W-1:0]  buf_o,
  output logic [PAGE_SIZE-1:0]              dirty_o
);

  logic [COL_W-1:0]                 col_q, col_d, wcol;
  logic [PAGE_SIZE-1:0]             dirty_q, dirty_d;
  logic [PAGE_SIZE-1:0][DATA_W-1:0] buf_q;

  // clear with load starts a fresh page at start_col; clear alone drops the mask
  always_comb begin
    wcol    = clear_i ? start_col_i : col_q;
    col_d   = col_q;
    dirty_d = dirty_q;
    if (load_i) begin
      dirty_d = (clear_i ? '0 : dirty_q) | (PAGE_SIZE'(1) << wcol);
      col_d   = COL_W'(wcol + 1'b1);
    end else if (clear_i) begin
      dirty_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      dirty_q <= '0;
    end else begin
      col_q   <= col_d;
      dirty_q <= dirty_d;
    end
  end

  // data bytes are not reset; only the dirty mask decides what gets committed
  always_ff @(posedge clk) begin
    if (load_i) begin
      buf_q[wcol] <= wdata_i;
    end
  end

  assign cur_col_o = col_q;
  assign buf_o     = buf_q;
  assign dirty_o   = dirty_q;

endmodule

// File: rtl/eeprom_page_core.sv
// 24Cxx-style EEPROM storage core: address pointer, page write buffer with
// column roll-over, sequential reads and a timed program cycle that NACKs.
module eeprom_page_core
  import eeprom_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PAGE_NUM  = 32,
  parameter int unsigned PAGE_SIZE = 8,
  parameter int unsigned WR_CYCLES = 16,
  localparam int unsigned ADDR_W   = $clog2(PAGE_NUM * PAGE_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic              rsp_nack,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int unsigned DEPTH = PAGE_NUM * PAGE_SIZE;
  localparam int unsigned COL_W = $clog2(PAGE_SIZE);
  localparam int unsigned CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] COL_MASK = ADDR_W'(PAGE_SIZE - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_nack_q, rsp_nack_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;

  logic                buf_clear, buf_load, commit;
  logic [COL_W-1:0]    cur_col;
  logic [PAGE_SIZE-1:0][DATA_W-1:0] buf_data;
  logic [PAGE_SIZE-1:0] buf_dirty;
  logic [ADDR_W-1:0]   page_base;
  op_e                 op;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign op        = op_e'(cmd_op);
  assign page_base = ptr_q & ~COL_MASK;

  eeprom_page_buf #(
    .DATA_W    (DATA_W),
    .PAGE_SIZE (PAGE_SIZE)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (buf_clear),
    .load_i      (buf_load),
    .wdata_i     (cmd_data),
    .start_col_i (ptr_q[COL_W-1:0]),
    .cur_col_o   (cur_col),
    .buf_o       (buf_data),
    .dirty_o     (buf_dirty)
  );

  // ptr holds the page start address during LOAD; the write column lives in the buffer
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = cmd_valid;
    rsp_nack_d  = RSP_ACK;
    rsp_data_d  = '0;
    buf_clear   = 1'b0;
    buf_load    = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_SET_ADDR: ptr_d = cmd_addr;
            OP_READ: begin
              rsp_data_d = mem_q[ptr_q];
              ptr_d      = ADDR_W'(ptr_q + 1'b1);
            end
            OP_WRITE: begin
              buf_clear = 1'b1;
              buf_load  = 1'b1;
              state_d   = LOAD;
            end
            default: ;
          endcase
        end
      end
      LOAD: begin
        if (cmd_valid) begin
          case (op)
            OP_WRITE: buf_load = 1'b1;
            OP_STOP: begin
              state_d = PROGRAM;
              cnt_d   = CNT_W'(WR_CYCLES - 1);
              ptr_d   = page_base | ADDR_W'(cur_col);
            end
            default: rsp_nack_d = RSP_NACK;
          endcase
        end
      end
      PROGRAM: begin
        rsp_nack_d = cmd_valid ? RSP_NACK : RSP_ACK;
        if (cnt_q == '0) begin
          commit    = 1'b1;
          buf_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PROGRAM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  // array is never reset; a reset during PROGRAM simply never reaches commit
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int c = 0; c < PAGE_SIZE; c++) begin
        if (buf_dirty[c]) begin
          mem_q[page_base | ADDR_W'(c)] <= buf_data[c];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_eeprom_page_core.sv
// Directed self-checking bench for eeprom_page_core at default parameters.
module tb_eeprom_page_core;

  localparam int unsigned WR = 16;
  localparam logic [1:0] C_SET  = 2'd0;
  localparam logic [1:0] C_WR   = 2'd1;
  localparam logic [1:0] C_RD   = 2'd2;
  localparam logic [1:0] C_STOP = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_addr = 8'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       rsp_valid, rsp_nack, busy;
  logic [7:0] rsp_data;

  int checks = 0;
  int errors = 0;

  eeprom_page_core #(
    .DATA_W    (8),
    .PAGE_NUM  (32),
    .PAGE_SIZE (8),
    .WR_CYCLES (WR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // issue one command at posedge+1, return the response seen one edge later
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        output logic n, output logic [7:0] r);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    n = rsp_nack;
    r = rsp_data;
  endtask

  task automatic cmd_exp(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] d, input logic exp_n, input logic [7:0] exp_r);
    logic n;
    logic [7:0] r;
    do_cmd(op, a, d, n, r);
    check({tag, "_nack"}, 32'(n), 32'(exp_n));
    check({tag, "_data"}, 32'(r), 32'(exp_r));
  endtask

  // READ every cycle until ACK; expects exactly WR NACKs and WR busy samples
  task automatic wait_prog(input string tag, output logic [7:0] last);
    int nacks;
    int busy_n;
    bit done;
    logic n;
    logic [7:0] r;
    nacks  = 0;
    done   = 1'b0;
    busy_n = busy ? 1 : 0;
    r      = 8'd0;
    for (int i = 0; i < 64 && !done; i++) begin
      do_cmd(C_RD, 8'd0, 8'd0, n, r);
      if (n) begin
        nacks++;
        if (r != 8'd0) check({tag, "_nack_data"}, 32'(r), 32'd0);
        if (busy) busy_n++;
      end else begin
        done = 1'b1;
      end
    end
    last = r;
    check({tag, "_nacks"}, 32'(nacks), 32'(WR));
    check({tag, "_busy"}, 32'(busy_n), 32'(WR));
  endtask

  initial begin
    logic [7:0] last;
    logic [7:0] roll_exp [9];
    roll_exp = '{8'h03, 8'h04, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'h01, 8'h02, 8'hC0};

    #12;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_nack", 32'(rsp_nack), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic write / poll / read back
    cmd_exp("b_set", C_SET, 8'h10, 8'h00, 1'b0, 8'h00);
    cmd_exp("b_w0", C_WR, 8'h00, 8'hA5, 1'b0, 8'h00);
    cmd_exp("b_w1", C_WR, 8'h00, 8'h5A, 1'b0, 8'h00);
    cmd_exp("b_stop", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    check("b_busy", 32'(busy), 32'd1);
    wait_prog("b_poll", last);
    check("b_busy_off", 32'(busy), 32'd0);
    cmd_exp("b_set2", C_SET, 8'h10, 8'h00, 1'b0, 8'h00);
    cmd_exp("b_r0", C_RD, 8'h00, 8'h00, 1'b0, 8'hA5);
    cmd_exp("b_r1", C_RD, 8'h00, 8'h00, 1'b0, 8'h5A);

    // preload page 0x18 and byte 0x20, then roll over inside page 0x18
    cmd_exp("p_set", C_SET, 8'h18, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cmd_exp("p_w", C_WR, 8'h00, 8'(8'hB0 + i), 1'b0, 8'h00);
    cmd_exp("p_stop", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_prog("p_poll", last);
    cmd_exp("q_set", C_SET, 8'h20, 8'h00, 1'b0, 8'h00);
    cmd_exp("q_w", C_WR, 8'h00, 8'hC0, 1'b0, 8'h00);
    cmd_exp("q_stop", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_prog("q_poll", last);
    cmd_exp("r_set", C_SET, 8'h1E, 8'h00, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) cmd_exp("r_w", C_WR, 8'h00, 8'(i), 1'b0, 8'h00);
    cmd_exp("r_stop", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_prog("r_poll", last);
    cmd_exp("r_set2", C_SET, 8'h18, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) cmd_exp($sformatf("r_rd%0d", i), C_RD, 8'h00, 8'h00, 1'b0, roll_exp[i]);

    // nine bytes into one page: column 0 written twice, last write wins
    cmd_exp("o_set", C_SET, 8'h30, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) cmd_exp("o_w", C_WR, 8'h00, 8'(8'h50 + i), 1'b0, 8'h00);
    cmd_exp("o_stop", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_prog("o_poll", last);
    check("o_ptr_read", 32'(last), 32'h51);
    cmd_exp("o_set2", C_SET, 8'h30, 8'h00, 1'b0, 8'h00);
    cmd_exp("o_r0", C_RD, 8'h00, 8'h00, 1'b0, 8'h58);
    cmd_exp("o_r1", C_RD, 8'h00, 8'h00, 1'b0, 8'h51);

    // sequential read wraps from the last byte to 0
    cmd_exp("w_set", C_SET, 8'hFF, 8'h00, 1'b0, 8'h00);
    cmd_exp("w_w", C_WR, 8'h00, 8'hEE, 1'b0, 8'h00);
    cmd_exp("w_stop", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_prog("w_poll", last);
    cmd_exp("w_set0", C_SET, 8'h00, 8'h00, 1'b0, 8'h00);
    cmd_exp("w_w0", C_WR, 8'h00, 8'hDD, 1'b0, 8'h00);
    cmd_exp("w_w1", C_WR, 8'h00, 8'h42, 1'b0, 8'h00);
    cmd_exp("w_stop0", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_prog("w_poll0", last);
    cmd_exp("w_set2", C_SET, 8'hFF, 8'h00, 1'b0, 8'h00);
    cmd_exp("w_rff", C_RD, 8'h00, 8'h00, 1'b0, 8'hEE);
    cmd_exp("w_r00", C_RD, 8'h00, 8'h00, 1'b0, 8'hDD);
    cmd_exp("w_r01", C_RD, 8'h00, 8'h00, 1'b0, 8'h42);

    // SET_ADDR and READ are rejected while loading a page
    cmd_exp("i_set41", C_SET, 8'h41, 8'h00, 1'b0, 8'h00);
    cmd_exp("i_w41", C_WR, 8'h00, 8'h99, 1'b0, 8'h00);
    cmd_exp("i_stop41", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_prog("i_poll41", last);
    cmd_exp("i_set", C_SET, 8'h40, 8'h00, 1'b0, 8'h00);
    cmd_exp("i_w", C_WR, 8'h00, 8'h11, 1'b0, 8'h00);
    cmd_exp("i_rd", C_RD, 8'h00, 8'h00, 1'b1, 8'h00);
    cmd_exp("i_setx", C_SET, 8'h00, 8'h00, 1'b1, 8'h00);
    cmd_exp("i_stop", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_prog("i_poll", last);
    check("i_ptr41", 32'(last), 32'h99);
    cmd_exp("i_set2", C_SET, 8'h40, 8'h00, 1'b0, 8'h00);
    cmd_exp("i_r40", C_RD, 8'h00, 8'h00, 1'b0, 8'h11);

    // reset in the middle of PROGRAM aborts the commit
    cmd_exp("x_set", C_SET, 8'h08, 8'h00, 1'b0, 8'h00);
    cmd_exp("x_w", C_WR, 8'h00, 8'h33, 1'b0, 8'h00);
    cmd_exp("x_stop", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_prog("x_poll", last);
    cmd_exp("y_set", C_SET, 8'h08, 8'h00, 1'b0, 8'h00);
    cmd_exp("y_w", C_WR, 8'h00, 8'h77, 1'b0, 8'h00);
    cmd_exp("y_stop", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cmd_exp("y_busy_rd", C_RD, 8'h00, 8'h00, 1'b1, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    check("y_rst_busy", 32'(busy), 32'd0);
    check("y_rst_valid", 32'(rsp_valid), 32'd0);
    check("y_rst_nack", 32'(rsp_nack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cmd_exp("y_set2", C_SET, 8'h08, 8'h00, 1'b0, 8'h00);
    cmd_exp("y_r08", C_RD, 8'h00, 8'h00, 1'b0, 8'h33);
    cmd_exp("y_stop_idle", C_STOP, 8'h00, 8'h00, 1'b0, 8'h00);
    check("y_idle_busy", 32'(busy), 32'd0);

    @(posedge clk);
    #1;
    check("idle_valid", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
